// File: rtl/ip_tx_scheduler.sv
// Two-channel IPv4 transmit scheduler: round-robin grant, sequential header
// checksum, 20-byte header emission, then payload pass-through of the winner.
module ip_tx_scheduler #(
    parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
    parameter logic [7:0]  IP_TTL   = 8'd64,
    parameter logic [7:0]  IP_PROTO = 8'd17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] len0,
    input  logic [31:0] dst0,
    output logic        gnt0,
    input  logic [7:0]  in0_data,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic        req1,
    input  logic [15:0] len1,
    input  logic [31:0] dst1,
    output logic        gnt1,
    input  logic [7:0]  in1_data,
    input  logic        in1_valid,
    output logic        in1_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StCsum, StFold, StHeader, StData} t_state;

    t_state      r_state, w_state_d;
    logic        r_ptr;      // 0: channel 0 has priority on contention
    logic        r_ch;
    logic [15:0] r_len;
    logic [31:0] r_dst;
    logic [15:0] r_id;
    logic [19:0] r_acc;
    logic [15:0] r_csum;
    logic [4:0]  r_cnt;      // CSUM word index, then HEADER byte index
    logic [15:0] r_rem;
    logic        r_gnt0, r_gnt1, r_err;

    logic        w_arb, w_win1, w_len_bad, w_hs;
    logic [15:0] w_req_len, w_totlen, w_word, w_fold;
    logic [31:0] w_req_dst;
    logic [3:0]  w_widx;
    logic [16:0] w_sum;

    // Arbitration is held off while a grant pulse is on the wire so a held
    // request is not granted twice.
    assign w_arb     = (r_state == StIdle) & (req0 | req1) & ~r_gnt0 & ~r_gnt1;
    assign w_win1    = req1 & (~req0 | r_ptr);
    assign w_req_len = w_win1 ? len1 : len0;
    assign w_req_dst = w_win1 ? dst1 : dst0;
    assign w_len_bad = w_req_len > 16'd65515;
    assign w_totlen  = r_len + 16'd20;

    // Header words double as checksum terms; word 5 is zero while summing.
    assign w_widx = (r_state == StHeader) ? r_cnt[4:1] : r_cnt[3:0];
    assign w_sum  = {1'b0, r_acc[15:0]} + {13'b0, r_acc[19:16]};
    assign w_fold = ~(w_sum[15:0] + {15'b0, w_sum[16]});

    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;
    assign err  = r_err;
    assign busy = (r_state != StIdle);

    // Select the 16-bit header word addressed by the current index.
    always_comb begin
        w_word = 16'h0000;
        case (w_widx)
            4'd0:    w_word = 16'h4500;
            4'd1:    w_word = w_totlen;
            4'd2:    w_word = r_id;
            4'd3:    w_word = 16'h4000;
            4'd4:    w_word = {IP_TTL, IP_PROTO};
            4'd5:    w_word = (r_state == StHeader) ? r_csum : 16'h0000;
            4'd6:    w_word = SRC_IP[31:16];
            4'd7:    w_word = SRC_IP[15:0];
            4'd8:    w_word = r_dst[31:16];
            4'd9:    w_word = r_dst[15:0];
            default: w_word = 16'h0000;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    // Next-state and output stream muxing.
    always_comb begin
        w_state_d = r_state;
        m_data    = 8'h00;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        w_hs      = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_arb && !w_len_bad) w_state_d = StCsum;
            end
            StCsum: begin
                if (r_cnt == 5'd9) w_state_d = StFold;
            end
            StFold: begin
                w_state_d = StHeader;
            end
            StHeader: begin
                m_valid = 1'b1;
                m_data  = r_cnt[0] ? w_word[7:0] : w_word[15:8];
                m_last  = (r_len == 16'd0) && (r_cnt == 5'd19);
                w_hs    = m_ready;
                if (w_hs && r_cnt == 5'd19) w_state_d = (r_len == 16'd0) ? StIdle : StData;
            end
            StData: begin
                m_data    = r_ch ? in1_data : in0_data;
                m_valid   = r_ch ? in1_valid : in0_valid;
                in0_ready = ~r_ch & m_ready;
                in1_ready = r_ch & m_ready;
                m_last    = (r_rem == 16'd1);
                w_hs      = m_valid & m_ready;
                if (w_hs && r_rem == 16'd1) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Request latch, grant pulses, checksum accumulation and byte counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= 1'b0;
            r_ch   <= 1'b0;
            r_len  <= 16'h0000;
            r_dst  <= 32'h0;
            r_id   <= 16'h0000;
            r_acc  <= 20'h0;
            r_csum <= 16'h0000;
            r_cnt  <= 5'd0;
            r_rem  <= 16'h0000;
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_arb) begin
                        r_ch   <= w_win1;
                        r_len  <= w_req_len;
                        r_dst  <= w_req_dst;
                        r_gnt0 <= ~w_win1;
                        r_gnt1 <= w_win1;
                        r_err  <= w_len_bad;
                        r_acc  <= 20'h0;
                        r_cnt  <= 5'd0;
                        if (!w_len_bad) r_ptr <= ~w_win1;
                    end
                end
                StCsum: begin
                    r_acc <= r_acc + {4'h0, w_word};
                    r_cnt <= (r_cnt == 5'd9) ? 5'd0 : r_cnt + 5'd1;
                end
                StFold: begin
                    r_csum <= w_fold;
                    r_cnt  <= 5'd0;
                end
                StHeader: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd19) begin
                            r_rem <= r_len;
                            if (r_len == 16'd0) r_id <= r_id + 16'd1;
                        end
                    end
                end
                StData: begin
                    if (w_hs) begin
                        r_rem <= r_rem - 16'd1;
                        if (r_rem == 16'd1) r_id <= r_id + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_tx_scheduler.sv
// Bench for ip_tx_scheduler: table of single-request vectors plus hand-written
// contention, length-limit and reset-abort sequences, checked by a byte scoreboard.
module tb_ip_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] len0 = '0, len1 = '0;
    logic [31:0] dst0 = '0, dst1 = '0;
    logic        gnt0, gnt1;
    logic [7:0]  in0_data = '0, in1_data = '0;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic        in0_ready, in1_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b0;
    logic        err, busy;

    always #5 clk = ~clk;

    ip_tx_scheduler dut (
        .clk(clk), .rst(rst),
        .req0(req0), .len0(len0), .dst0(dst0), .gnt0(gnt0),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .req1(req1), .len1(len1), .dst1(dst1), .gnt1(gnt1),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .err(err), .busy(busy)
    );

    typedef struct {
        logic [15:0] len;
        logic [31:0] dst;
        bit          exp_err;
    } req_t;

    typedef struct {
        int          ch;
        logic [15:0] len;
        logic [31:0] dst;
        bit          bp;
        bit          exp_err;
        logic [15:0] exp_totlen;
    } vec_t;

    req_t        pend0[$], pend1[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  src0[$], src1[$];
    int          gnt_log[$];
    logic [15:0] id_log[$];
    logic [7:0]  hdr[20];

    int unsigned cyc = 0, gnt_cyc = 0;
    int          n_tests = 0, n_fail = 0;
    bit          bp = 1'b0;
    int          cap = 65536;
    logic [15:0] model_id = '0;
    bit          hs0, hs1, gseen0, gseen1, wait_first, prev_stall;
    bit          rdy_seen0, rdy_seen1;
    logic [7:0]  prev_data;
    int          byte_idx = 0, last_cnt = 0;

    req_t        mr;
    int          mch;
    logic [8:0]  me;
    logic [7:0]  mb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference header byte, checksum folded with end-around carry per add.
    function automatic logic [7:0] hdr_byte(input int k, input logic [15:0] len,
                                            input logic [31:0] dst, input logic [15:0] id);
        logic [15:0] w[10];
        logic [31:0] s;
        w = '{16'h4500, len + 16'd20, id, 16'h4000, 16'h4011, 16'h0000,
              16'hC0A8, 16'h0001, dst[31:16], dst[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) begin
            s = s + {16'h0, w[i]};
            if (s[16]) s = {16'h0, s[15:0]} + 32'd1;
        end
        w[5] = ~s[15:0];
        return k[0] ? w[k / 2][7:0] : w[k / 2][15:8];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: grants feed the scoreboard, handshakes drain it.
    always @(negedge clk) begin
        hs0 = 1'b0; hs1 = 1'b0; gseen0 = 1'b0; gseen1 = 1'b0;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (gnt0 || gnt1 || err) begin
                chk("gnt_onehot", {31'h0, gnt0 & gnt1}, 0);
                chk("err_with_gnt", {31'h0, err & ~(gnt0 | gnt1)}, 0);
            end
            if (gnt0 || gnt1) begin
                mch = gnt1 ? 1 : 0;
                chk("gnt_has_req", (mch == 1 ? pend1.size() : pend0.size()) > 0, 1);
                mr = (mch == 1) ? pend1[0] : pend0[0];
                chk("gnt_err", {31'h0, err}, {31'h0, mr.exp_err});
                gnt_log.push_back(mch);
                if (mch == 1) gseen1 = 1'b1; else gseen0 = 1'b1;
                if (!err) begin
                    for (int k = 0; k < 20; k++)
                        exp_q.push_back({(mr.len == 16'd0 && k == 19),
                                         hdr_byte(k, mr.len, mr.dst, model_id)});
                    for (int i = 0; i < int'(mr.len) && i < cap; i++) begin
                        mb = 8'($urandom());
                        if (mch == 1) src1.push_back(mb); else src0.push_back(mb);
                        exp_q.push_back({(i == int'(mr.len) - 1), mb});
                    end
                    model_id   = model_id + 16'd1;
                    byte_idx   = 0;
                    gnt_cyc    = cyc;
                    wait_first = 1'b1;
                end
            end
            if (wait_first && m_valid) begin
                chk("first_byte_latency", cyc - gnt_cyc, 11);
                wait_first = 1'b0;
            end
            if (prev_stall && m_valid) chk("stable_under_stall", {24'h0, m_data}, {24'h0, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {31'h0, m_valid}, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("m_data", {24'h0, m_data}, {24'h0, me[7:0]});
                    chk("m_last", {31'h0, m_last}, {31'h0, me[8]});
                end
                if (byte_idx < 20) hdr[byte_idx] = m_data;
                if (byte_idx == 5) id_log.push_back({hdr[4], hdr[5]});
                byte_idx++;
                if (m_last) last_cnt++;
            end
            if (in0_ready) begin
                rdy_seen0 = 1'b1;
                chk("in0_ready_ctx", {29'h0, in1_ready, busy, m_valid == in0_valid}, 3'b011);
            end
            if (in1_ready) begin
                rdy_seen1 = 1'b1;
                chk("in1_ready_ctx", {29'h0, in0_ready, busy, m_valid == in1_valid}, 3'b011);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            hs0 = in0_valid && in0_ready;
            hs1 = in1_valid && in1_ready;
        end
    end

    // Requesters and payload sources; random stalls when bp is set.
    always @(posedge clk) begin
        #1;
        if (hs0 && src0.size() > 0) void'(src0.pop_front());
        if (hs1 && src1.size() > 0) void'(src1.pop_front());
        if (gseen0 && pend0.size() > 0) void'(pend0.pop_front());
        if (gseen1 && pend1.size() > 0) void'(pend1.pop_front());
        req0 = pend0.size() > 0;
        req1 = pend1.size() > 0;
        if (req0) begin len0 = pend0[0].len; dst0 = pend0[0].dst; end
        if (req1) begin len1 = pend1[0].len; dst1 = pend1[0].dst; end
        in0_valid = (src0.size() > 0) && (!bp || $urandom_range(1) == 1);
        in1_valid = (src1.size() > 0) && (!bp || $urandom_range(1) == 1);
        in0_data  = (src0.size() > 0) ? src0[0] : 8'h00;
        in1_data  = (src1.size() > 0) ? src1[0] : 8'h00;
        m_ready   = !bp || $urandom_range(1) == 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string name);
        chk(name, {16'h0, gnt0, gnt1, err, busy, m_valid, m_last, in0_ready, in1_ready, m_data}, 0);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        tick(); tick();
        while ((exp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, n < budget, 1);
        repeat (2) tick();
    endtask

    // Assert reset for one edge starting now; flush all expectations.
    task automatic apply_reset(input string name);
        rst = 1'b1;
        tick();
        chk_idle(name);
        rst = 1'b0;
        exp_q.delete(); src0.delete(); src1.delete();
        model_id   = '0;
        wait_first = 1'b0;
    endtask

    initial begin
        vec_t        vec[5];
        logic [7:0]  hdr_ref[20];
        int          gnt_ref[4];
        int          accepted = 0;
        int          n;
        req_t        r;

        vec[0] = '{ch: 0, len: 16'd8,     dst: 32'hC0A80002, bp: 0, exp_err: 0, exp_totlen: 16'h001C};
        vec[1] = '{ch: 0, len: 16'd8,     dst: 32'hC0A80002, bp: 1, exp_err: 0, exp_totlen: 16'h001C};
        vec[2] = '{ch: 1, len: 16'd0,     dst: 32'h0A000001, bp: 0, exp_err: 0, exp_totlen: 16'h0014};
        vec[3] = '{ch: 1, len: 16'd100,   dst: 32'h0A0A0A0A, bp: 1, exp_err: 0, exp_totlen: 16'h0078};
        vec[4] = '{ch: 0, len: 16'd65516, dst: 32'hC0A80009, bp: 0, exp_err: 1, exp_totlen: 16'h0000};
        hdr_ref = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                    8'hB9, 8'h7D, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02};
        gnt_ref = '{0, 1, 0, 1};

        repeat (3) tick();
        chk_idle("reset_outputs");
        rst = 1'b0;
        tick();
        chk_idle("idle_after_reset");

        for (int v = 0; v < 5; v++) begin
            bp = vec[v].bp;
            last_cnt = 0; rdy_seen0 = 1'b0; rdy_seen1 = 1'b0;
            gnt_log.delete();
            r = '{len: vec[v].len, dst: vec[v].dst, exp_err: vec[v].exp_err};
            if (vec[v].ch == 1) pend1.push_back(r); else pend0.push_back(r);
            wait_done(5000, "vec_done");
            chk("vec_gnt_count", gnt_log.size(), 1);
            chk("vec_last_count", last_cnt, vec[v].exp_err ? 0 : 1);
            if (!vec[v].exp_err) begin
                chk("vec_totlen", {16'h0, hdr[2], hdr[3]}, {16'h0, vec[v].exp_totlen});
                chk("vec_id", {16'h0, hdr[4], hdr[5]}, accepted);
                accepted++;
            end
            if (vec[v].len == 16'd0)
                chk("zero_len_no_ready", {31'h0, vec[v].ch == 1 ? rdy_seen1 : rdy_seen0}, 0);
            if (v == 0)
                for (int k = 0; k < 20; k++) chk("ref_header", {24'h0, hdr[k]}, {24'h0, hdr_ref[k]});
        end

        // Largest legal length: header then abort by reset mid-payload.
        bp = 1'b0; cap = 3; last_cnt = 0; byte_idx = 0;
        pend0.push_back('{len: 16'd65515, dst: 32'hC0A80003, exp_err: 1'b0});
        n = 0;
        while (!(byte_idx == 23 && exp_q.size() == 0) && n < 500) begin tick(); n++; end
        chk("max_len_progress", n < 500, 1);
        chk("max_len_totlen", {16'h0, hdr[2], hdr[3]}, 32'h0000FFFF);
        chk("id_unchanged_by_err", {16'h0, hdr[4], hdr[5]}, accepted);
        chk("max_len_still_busy", {31'h0, busy}, 1);
        chk("max_len_no_last", last_cnt, 0);
        apply_reset("abort_max_len");
        cap = 65536;

        // Contention: both channels keep requesting.
        gnt_log.delete(); id_log.delete();
        pend0.push_back('{len: 16'd4, dst: 32'h0A000010, exp_err: 1'b0});
        pend0.push_back('{len: 16'd5, dst: 32'h0A000011, exp_err: 1'b0});
        pend1.push_back('{len: 16'd6, dst: 32'h0A000020, exp_err: 1'b0});
        pend1.push_back('{len: 16'd7, dst: 32'h0A000021, exp_err: 1'b0});
        wait_done(3000, "rr_done");
        chk("rr_gnt_count", gnt_log.size(), 4);
        chk("rr_id_count", id_log.size(), 4);
        if (gnt_log.size() == 4 && id_log.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("rr_order", gnt_log[i], gnt_ref[i]);
                chk("rr_id", {16'h0, id_log[i]}, i);
            end

        // Reset while payload byte 3 of 8 is on the output.
        pend1.push_back('{len: 16'd8, dst: 32'hC0A80004, exp_err: 1'b0});
        byte_idx = 0;
        n = 0;
        tick(); tick();
        while (byte_idx != 22 && n < 200) begin tick(); n++; end
        chk("abort_reached_byte3", n < 200, 1);
        chk("abort_busy_before", {31'h0, busy}, 1);
        apply_reset("abort_payload");
        tick();
        chk_idle("idle_after_abort");
        gnt_log.delete(); id_log.delete();
        pend0.push_back('{len: 16'd3, dst: 32'h0A000030, exp_err: 1'b0});
        pend1.push_back('{len: 16'd3, dst: 32'h0A000031, exp_err: 1'b0});
        wait_done(1000, "post_reset_done");
        chk("post_reset_gnt_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2 && id_log.size() == 2) begin
            chk("post_reset_first_ch", gnt_log[0], 0);
            chk("post_reset_first_id", {16'h0, id_log[0]}, 0);
            chk("post_reset_second_ch", gnt_log[1], 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_tx_scheduler.md
Name: ip_tx_scheduler

Overview:
- Two-channel transmit scheduler in front of the Ethernet IPv4 framer.
- Arbitrates round-robin between two UDP payload sources and computes the IPv4 header checksum sequentially (one 16-bit word per cycle).
- Emits the 20-byte IPv4 header, then forwards the granted channel's payload as one byte stream.
- Output feeds the MAC framing stage through a valid/ready byte interface.

Parameters:
SRC_IP, 32'hC0A8_0001, source address placed in every header
IP_TTL, 8'd64, time-to-live field
IP_PROTO, 8'd17, protocol field (UDP)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req0  in  1  channel 0 request; held until gnt0
len0  in  16  channel 0 payload length in bytes, valid with req0
dst0  in  32  channel 0 destination IP, valid with req0
gnt0  out  1  one-cycle grant pulse, channel 0
in0_data  in  8  channel 0 payload byte
in0_valid  in  1  channel 0 payload valid
in0_ready  out  1  channel 0 payload ready
req1, len1, dst1, gnt1, in1_data, in1_valid, in1_ready: same as channel 0, for channel 1
m_data  out  8  output byte, header MSB-first, then payload
m_valid  out  1  output valid
m_last  out  1  final byte of datagram
m_ready  in  1  downstream ready
err  out  1  one-cycle pulse: request rejected (length too large)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; ID counter 0; round-robin pointer selects channel 0 first.
- Reset asserted mid-datagram aborts it immediately. No m_last is produced, and the truncated datagram is not completed after reset.
- States: IDLE -> CSUM -> FOLD -> HEADER -> DATA -> IDLE.
- IDLE arbitration:
  - If only one req is high, that channel wins.
  - If both are high, the pointer's channel wins. The pointer then points to the other channel.
  - Pointer changes only on an accepted grant.
- IDLE latch: on the cycle a winner is chosen, the block latches channel, len and dst.
- Length check:
  - len > 65515: next cycle pulses gnt and err together, stays IDLE, no output, ID unchanged.
  - Otherwise: next cycle pulses gnt only and enters CSUM.
- CSUM (exactly 10 cycles): adds one 16-bit header word per cycle into a 20-bit accumulator, in this order:
  4500, TotLen = len+20, ID, 4000 (DF set, offset 0), {TTL, PROTO}, 0000, SRC_IP[31:16], SRC_IP[15:0], dst[31:16], dst[15:0].
- FOLD (1 cycle): s = acc[15:0] + acc[19:16]; csum = ~(s[15:0] + s[16]).
- HEADER:
  - Presents 20 bytes in network order: 45 00 TotLen ID 40 00 TTL PROTO csum SRC dst.
  - A byte counter (0..19) advances on m_valid & m_ready.
  - m_valid stays high throughout.
  - m_data must stay stable while m_ready is low.
- Latency: the first header byte appears with m_valid 11 cycles after the gnt pulse.
- DATA:
  - Output is a pure combinational pass-through of the selected channel: m_data = inX_data, m_valid = inX_valid, inX_ready = m_ready.
  - The unselected channel's in_ready stays 0.
  - A 16-bit remaining counter decrements on each handshake.
  - m_last is high with the byte for which remaining == 1.
- len == 0: DATA is skipped, and m_last is asserted on header byte 19.
- End of datagram: on the m_last handshake the ID increments (wrapping 0xFFFF -> 0) and the state returns to IDLE.
- Back-to-back: the next arbitration starts in the first IDLE cycle after m_last.
- A req raised while busy waits. The requester holds req, len and dst until its gnt.
- in_ready is never high outside DATA.

Test Plan:
1. Channel 0 only, len0 = 8, dst0 = C0A80002, m_ready = 1:
   - gnt0 pulses once.
   - 11 cycles later header bytes are 45 00 00 1C 00 00 40 00 40 11 B9 7D C0 A8 00 01 C0 A8 00 02.
   - 8 payload bytes follow, with m_last on the 28th byte.
2. req0 and req1 high together, three consecutive datagrams:
   - Grants go ch0, ch1, ch0.
   - Header ID fields read 0000, 0001, 0002.
   - Checksums are recomputed correctly for each (ID changes the checksum).
3. Backpressure: toggle m_ready randomly 50% during header and payload:
   - The byte sequence is identical to test 1.
   - m_data never changes while m_valid & ~m_ready.
   - The source's in_valid stalls are respected.
4. len1 = 0 -> exactly 20 bytes, m_last on byte 20, TotLen 0014, in1_ready never asserted.
5. len0 = 65516 -> gnt0 and err pulse the same cycle, no m_valid, ID unchanged. A following len0 = 65515 request is accepted with TotLen FFFF.
6. rst asserted during payload byte 3 of 8:
   - Next cycle all outputs are 0 and busy = 0.
   - A new request gets grant priority on ch0 and ID 0000.
